// File: rtl/multicycle_sequencer_pkg.sv
// Shared RV32I control definitions: opcodes, sequencer state and encodings.
// Also imported by the combinational decoder.
package rv_pkg;

   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'b00,
      PC_REL   = 2'b01,
      PC_JALR  = 2'b10
   } pc_sel_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_BUS     = 2'b10
   } trap_cause_e;

   // One-hot instruction class; all zero for an illegal encoding.
   typedef struct packed {
      logic r;
      logic i_alu;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic lui;
      logic auipc;
   } instr_class_t;

   function automatic logic writes_rd(input instr_class_t c);
      return c.r | c.i_alu | c.load | c.jal | c.jalr | c.lui | c.auipc;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the datapath/memories.
interface multicycle_sequencer_if #(
   parameter int CNT_W = 32
);

   logic [31:0]      instr;
   logic             imem_ready;
   logic             dmem_ready;
   logic             branch_taken;

   logic             imem_req;
   logic             ir_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             reg_we;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             retire;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instret;
   logic [2:0]       state;

   modport master (
      input  instr, imem_ready, dmem_ready, branch_taken,
      output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
             retire, trap, trap_cause, instret, state
   );

   modport slave (
      output instr, imem_ready, dmem_ready, branch_taken,
      input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
             retire, trap, trap_cause, instret, state
   );

endinterface

// File: rtl/multicycle_sequencer_classifier.sv
// Combinational opcode classifier: one-hot instruction class plus illegal flag.
module opcode_classifier
   import rv_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   output instr_class_t cls,
   output logic         illegal
);

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      cls     = '0;
      illegal = 1'b0;
      unique case (opcode)
         OP_R:      cls.r      = 1'b1;
         OP_I_ALU:  cls.i_alu  = 1'b1;
         OP_LOAD:   cls.load   = 1'b1;
         OP_STORE:  cls.store  = 1'b1;
         OP_BRANCH: cls.branch = 1'b1;
         OP_JAL:    cls.jal    = 1'b1;
         OP_LUI:    cls.lui    = 1'b1;
         OP_AUIPC:  cls.auipc  = 1'b1;
         OP_JALR: begin
            // JALR is only defined with funct3 = 000.
            cls.jalr = (funct3 == 3'b000);
            illegal  = (funct3 != 3'b000);
         end
         default:   illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB phasing, memory
// handshakes, PC-update select, trap detection and retired-instruction count.
module multicycle_sequencer
   import rv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,   // 1..255
   parameter int CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_sequencer_if.master bus
);

   localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       mem_cnt_q, mem_cnt_d;
   trap_cause_e      cause_q, cause_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   instr_class_t     cls;
   logic             illegal;
   logic             rd_nonzero;

   logic             imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire, trap;
   pc_sel_e          pc_sel;

   opcode_classifier u_classifier (
      .opcode  (bus.instr[6:0]),
      .funct3  (bus.instr[14:12]),
      .cls     (cls),
      .illegal (illegal)
   );

   assign rd_nonzero = |bus.instr[11:7];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         mem_cnt_q <= '0;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_cnt_q <= mem_cnt_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_cnt_d = mem_cnt_q;
      cause_d   = cause_q;
      instret_d = instret_q;
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      retire    = 1'b0;
      trap      = 1'b0;

      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (illegal) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            mem_cnt_d = '0;
            state_d   = (cls.load || cls.store) ? ST_MEM : ST_WB;
         end

         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = cls.store;
            // A response in the last allowed cycle still completes the access.
            if (bus.dmem_ready) begin
               state_d = ST_WB;
            end else if (mem_cnt_q == MEM_LAST) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_BUS;
            end else begin
               mem_cnt_d = mem_cnt_q + 8'd1;
            end
         end

         ST_WB: begin
            pc_we     = 1'b1;
            reg_we    = writes_rd(cls) && rd_nonzero;
            retire    = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
            if (cls.jal || (cls.branch && bus.branch_taken)) begin
               pc_sel = PC_REL;
            end else if (cls.jalr) begin
               pc_sel = PC_JALR;
            end
         end

         ST_TRAP: begin
            trap = 1'b1;
         end

         default: begin
            // Encodings 6 and 7 are unreachable; treat a corrupted state as illegal.
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase
   end

   // Everything reads as zero while reset is held, even before the state register clears.
   assign bus.imem_req   = imem_req & ~rst;
   assign bus.ir_we      = ir_we    & ~rst;
   assign bus.dmem_req   = dmem_req & ~rst;
   assign bus.dmem_we    = dmem_we  & ~rst;
   assign bus.reg_we     = reg_we   & ~rst;
   assign bus.pc_we      = pc_we    & ~rst;
   assign bus.retire     = retire   & ~rst;
   assign bus.trap       = trap     & ~rst;
   assign bus.pc_sel     = rst ? 2'b00 : pc_sel;
   assign bus.trap_cause = rst ? 2'b00 : cause_q;
   assign bus.instret    = rst ? '0 : instret_q;
   assign bus.state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-scenario tasks with a
// retirement scoreboard filled when instructions are issued.
module tb_multicycle_sequencer;
   import rv_pkg::*;

   localparam int MAX_CYC = 100;

   typedef struct packed {
      logic        reg_we;
      logic [1:0]  pc_sel;
      logic [31:0] instret;
   } exp_t;

   typedef struct {
      int          cycles;
      int          ir_we_n;
      int          ir_we_first;
      int          dmem_req_n;
      int          dmem_we_n;
      int          pc_we_n;
      int          retire_n;
      logic [63:0] trace;
   } obs_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [31:0] exp_instret;
   exp_t sb_q[$];

   multicycle_sequencer_if #(.CNT_W(32)) bus ();

   multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic expect_retire(input logic reg_we, input logic [1:0] pc_sel);
      sb_q.push_back('{reg_we, pc_sel, exp_instret});
      exp_instret = exp_instret + 32'd1;
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_instret = '0;
      sb_q.delete();
   endtask

   // Runs one instruction from FETCH until WB or TRAP is observed; called at posedge+1.
   task automatic drive_instr(input logic [31:0] word, input int fetch_wait,
                              input int mem_ready_cycle, input logic taken, output obs_t o);
      int fcnt, mcnt;
      logic [2:0] st;
      logic done;
      exp_t e;
      o.cycles = 0; o.ir_we_n = 0; o.ir_we_first = -1; o.dmem_req_n = 0;
      o.dmem_we_n = 0; o.pc_we_n = 0; o.retire_n = 0; o.trace = '0;
      fcnt = 0; mcnt = 0; done = 1'b0;
      for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
         st = bus.state;
         bus.instr        = word;
         bus.branch_taken = taken;
         bus.imem_ready   = (st == ST_FETCH) && (fcnt >= fetch_wait);
         bus.dmem_ready   = (st == ST_MEM) && (mcnt + 1 == mem_ready_cycle);
         @(negedge clk);
         o.cycles++;
         o.trace = {o.trace[60:0], bus.state};
         if (bus.ir_we) begin
            o.ir_we_n++;
            if (o.ir_we_first < 0) o.ir_we_first = cyc;
         end
         if (bus.dmem_req) o.dmem_req_n++;
         if (bus.dmem_we)  o.dmem_we_n++;
         if (bus.pc_we)    o.pc_we_n++;
         if (bus.retire) begin
            o.retire_n++;
            n_checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected_retire: got retire for %h expected none", word);
            end else begin
               n_pass++;
               e = sb_q.pop_front();
               n_checks++;
               if (bus.reg_we !== e.reg_we)
                  $display("FAIL sb_reg_we %h: got %b expected %b", word, bus.reg_we, e.reg_we);
               else n_pass++;
               n_checks++;
               if (bus.pc_sel !== e.pc_sel)
                  $display("FAIL sb_pc_sel %h: got %b expected %b", word, bus.pc_sel, e.pc_sel);
               else n_pass++;
               n_checks++;
               if (bus.instret !== e.instret)
                  $display("FAIL sb_instret %h: got %0d expected %0d", word, bus.instret, e.instret);
               else n_pass++;
            end
         end
         if (st == ST_FETCH) fcnt++;
         if (st == ST_MEM)   mcnt++;
         done = (bus.state == ST_WB) || (bus.state == ST_TRAP);
         @(posedge clk);
         #1;
      end
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      if (!done) begin
         n_checks++;
         $display("FAIL drive_timeout %h: got no WB/TRAP expected one within %0d cycles", word, MAX_CYC);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (bus.state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_imem_req: got %b expected 0", bus.imem_req); else n_pass++;
      n_checks++; if (bus.instret !== 32'd0) $display("FAIL rst_instret: got %0d expected 0", bus.instret); else n_pass++;
      n_checks++; if (bus.trap_cause !== 2'b00) $display("FAIL rst_cause: got %b expected 00", bus.trap_cause); else n_pass++;
      n_checks++; if (bus.trap !== 1'b0) $display("FAIL rst_trap: got %b expected 0", bus.trap); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL post_rst_imem_req: got %b expected 1", bus.imem_req); else n_pass++;
      n_checks++; if (bus.state !== ST_FETCH) $display("FAIL post_rst_state: got %0d expected 0", bus.state); else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu();
      obs_t o;
      expect_retire(1'b1, PC_PLUS4);
      drive_instr(32'h002081B3, 0, 0, 1'b0, o);   // add x3,x1,x2
      n_checks++; if (o.cycles !== 4) $display("FAIL add_cycles: got %0d expected 4", o.cycles); else n_pass++;
      n_checks++; if (o.trace !== 64'o124) $display("FAIL add_trace: got %o expected 124", o.trace); else n_pass++;
      n_checks++; if (o.ir_we_first !== 0 || o.ir_we_n !== 1)
         $display("FAIL add_ir_we: got first=%0d n=%0d expected first=0 n=1", o.ir_we_first, o.ir_we_n); else n_pass++;
      n_checks++; if (o.pc_we_n !== 1 || o.retire_n !== 1)
         $display("FAIL add_pc_we_retire: got %0d/%0d expected 1/1", o.pc_we_n, o.retire_n); else n_pass++;
      n_checks++; if (bus.instret !== 32'd1) $display("FAIL add_instret: got %0d expected 1", bus.instret); else n_pass++;
      expect_retire(1'b0, PC_PLUS4);
      drive_instr(32'h00208033, 0, 0, 1'b0, o);   // add x0,x1,x2: rd = 0
      n_checks++; if (bus.instret !== exp_instret) $display("FAIL add_x0_instret: got %0d expected %0d", bus.instret, exp_instret); else n_pass++;
   endtask

   task automatic test_back_to_back();
      obs_t o;
      logic [31:0] words [5] = '{32'h00100093, 32'h000012B7, 32'h00000217, 32'h008000EF, 32'h000100E7};
      logic [1:0]  sels  [5] = '{PC_PLUS4, PC_PLUS4, PC_PLUS4, PC_REL, PC_JALR};
      for (int i = 0; i < 5; i++) begin
         expect_retire(1'b1, sels[i]);
         drive_instr(words[i], 0, 0, 1'b0, o);
         n_checks++; if (o.cycles !== 4) $display("FAIL b2b_cycles[%0d]: got %0d expected 4", i, o.cycles); else n_pass++;
      end
      n_checks++; if (bus.instret !== exp_instret) $display("FAIL b2b_instret: got %0d expected %0d", bus.instret, exp_instret); else n_pass++;
   endtask

   task automatic test_load();
      obs_t o;
      expect_retire(1'b1, PC_PLUS4);
      drive_instr(32'h0000A183, 0, 3, 1'b0, o);   // lw x3,0(x1)
      n_checks++; if (o.cycles !== 7) $display("FAIL lw_cycles: got %0d expected 7", o.cycles); else n_pass++;
      n_checks++; if (o.trace !== 64'o123334) $display("FAIL lw_trace: got %o expected 123334", o.trace); else n_pass++;
      n_checks++; if (o.dmem_req_n !== 3 || o.dmem_we_n !== 0)
         $display("FAIL lw_dmem: got req=%0d we=%0d expected req=3 we=0", o.dmem_req_n, o.dmem_we_n); else n_pass++;
   endtask

   task automatic test_mem_ready_at_timeout();
      obs_t o;
      expect_retire(1'b0, PC_PLUS4);
      drive_instr(32'h0020A023, 0, 16, 1'b0, o);  // sw, ready in last allowed cycle
      n_checks++; if (o.cycles !== 20 || bus.trap !== 1'b0)
         $display("FAIL sw_ready_wins: got cycles=%0d trap=%b expected 20/0", o.cycles, bus.trap); else n_pass++;
      n_checks++; if (o.dmem_we_n !== 16) $display("FAIL sw_ready_we: got %0d expected 16", o.dmem_we_n); else n_pass++;
   endtask

   task automatic test_branch();
      obs_t o;
      expect_retire(1'b0, PC_REL);
      drive_instr(32'h00208463, 0, 0, 1'b1, o);   // beq taken
      expect_retire(1'b0, PC_PLUS4);
      drive_instr(32'h00208463, 0, 0, 1'b0, o);   // beq not taken
      n_checks++; if (bus.instret !== exp_instret) $display("FAIL beq_instret: got %0d expected %0d", bus.instret, exp_instret); else n_pass++;
   endtask

   task automatic test_store_timeout();
      obs_t o;
      drive_instr(32'h0020A023, 0, 0, 1'b0, o);   // sw, never ready
      n_checks++; if (o.dmem_we_n !== 16 || o.dmem_req_n !== 16)
         $display("FAIL sw_to_dmem: got we=%0d req=%0d expected 16/16", o.dmem_we_n, o.dmem_req_n); else n_pass++;
      n_checks++; if (o.pc_we_n !== 0 || o.retire_n !== 0)
         $display("FAIL sw_to_pc_we_retire: got %0d/%0d expected 0/0", o.pc_we_n, o.retire_n); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (bus.trap !== 1'b1 || bus.trap_cause !== CAUSE_BUS || bus.state !== ST_TRAP)
            $display("FAIL sw_to_trap[%0d]: got trap=%b cause=%b state=%0d expected 1/10/5", i, bus.trap, bus.trap_cause, bus.state); else n_pass++;
         n_checks++; if (bus.pc_we !== 1'b0 || bus.imem_req !== 1'b0)
            $display("FAIL sw_to_strobes[%0d]: got pc_we=%b imem_req=%b expected 0/0", i, bus.pc_we, bus.imem_req); else n_pass++;
         @(posedge clk);
         #1;
      end
      do_reset(1);
   endtask

   task automatic test_illegal();
      obs_t o;
      logic [31:0] words [2] = '{32'hFFFFFFFF, 32'h000110E7};  // bad opcode, jalr funct3=001
      for (int i = 0; i < 2; i++) begin
         drive_instr(words[i], 0, 0, 1'b0, o);
         n_checks++; if (o.trace !== 64'o15) $display("FAIL ill_trace[%0d]: got %o expected 15", i, o.trace); else n_pass++;
         @(negedge clk);
         n_checks++; if (bus.trap !== 1'b1 || bus.trap_cause !== CAUSE_ILLEGAL)
            $display("FAIL ill_cause[%0d]: got trap=%b cause=%b expected 1/01", i, bus.trap, bus.trap_cause); else n_pass++;
         @(posedge clk);
         #1;
         do_reset(1);
         @(negedge clk);
         n_checks++; if (bus.state !== ST_FETCH || bus.trap !== 1'b0 || bus.trap_cause !== 2'b00)
            $display("FAIL ill_rst_state[%0d]: got state=%0d trap=%b cause=%b expected 0/0/00", i, bus.state, bus.trap, bus.trap_cause); else n_pass++;
         n_checks++; if (bus.instret !== 32'd0 || bus.imem_req !== 1'b1)
            $display("FAIL ill_rst_out[%0d]: got instret=%0d imem_req=%b expected 0/1", i, bus.instret, bus.imem_req); else n_pass++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_fetch_wait_reset();
      obs_t o;
      logic reached;
      expect_retire(1'b1, PC_PLUS4);
      drive_instr(32'h002081B3, 0, 0, 1'b0, o);   // make instret nonzero first
      reached = 1'b0;
      bus.instr = 32'h0000A183;
      bus.dmem_ready = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         bus.imem_ready = (bus.state == ST_FETCH);
         @(posedge clk);
         #1;
         reached = (bus.state == ST_MEM);
      end
      n_checks++; if (!reached) $display("FAIL fwr_reach_mem: got state=%0d expected 3", bus.state); else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.dmem_req !== 1'b0 || bus.state !== 3'd0)
         $display("FAIL fwr_in_rst: got dmem_req=%b state=%0d expected 0/0", bus.dmem_req, bus.state); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_instret = '0;
      sb_q.delete();
      expect_retire(1'b1, PC_PLUS4);
      drive_instr(32'h002081B3, 5, 0, 1'b0, o);
      n_checks++; if (o.dmem_req_n !== 0) $display("FAIL fwr_dmem_req: got %0d expected 0", o.dmem_req_n); else n_pass++;
      n_checks++; if (o.ir_we_first !== 5 || o.ir_we_n !== 1)
         $display("FAIL fwr_ir_we: got first=%0d n=%0d expected 5/1", o.ir_we_first, o.ir_we_n); else n_pass++;
      n_checks++; if (o.cycles !== 9) $display("FAIL fwr_cycles: got %0d expected 9", o.cycles); else n_pass++;
      n_checks++; if (bus.instret !== 32'd1) $display("FAIL fwr_instret: got %0d expected 1", bus.instret); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      exp_instret = '0;
      rst = 1'b1;
      bus.instr = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.branch_taken = 1'b0;

      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_mem_ready_at_timeout();
      test_branch();
      test_store_timeout();
      test_illegal();
      test_fetch_wait_reset();

      n_checks++;
      if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
      else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the RISC-V core. It sequences the shared datapath (PC, instruction register, register file, ALU, data memory) through FETCH / DECODE / EXEC / MEM / WB phases, one instruction at a time. The combinational decoder still produces the ALU and memory-format controls. This block adds phase timing, the memory handshakes, PC update selection, trap detection and retired-instruction counting.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent waiting for dmem_ready in MEM before a bus-error trap (range 1..255).
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  current IR contents (opcode [6:0], funct3 [14:12], rd [11:7])
- imem_ready  in  1  instruction memory has valid data this cycle
- dmem_ready  in  1  data memory access complete this cycle
- branch_taken  in  1  branch comparison result from the ALU/comparator, valid in EXEC and WB
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load IR from instruction memory
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (stores); valid only with dmem_req
- reg_we  out  1  register file write enable
- pc_we  out  1  PC update enable
- pc_sel  out  2  00 = PC+4, 01 = PC+imm (taken branch, JAL), 10 = (rs1+imm)&~1 (JALR)
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky; core halted
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = data bus timeout
- instret  out  CNT_W  retired-instruction count
- state  out  3  current FSM state (debug)

Behaviour:
- Reset: while rst=1, the state is FETCH and every output is 0, including imem_req, instret and trap_cause. Reset wins over all events, including mid-MEM and TRAP.
- All outputs are Moore decodes of the state, plus a qualified dmem_ready/imem_ready where noted.
- FETCH (encoding 0):
  - imem_req=1 while waiting.
  - On imem_ready=1: ir_we=1 in that same cycle, next state DECODE.
  - Otherwise hold with no timeout.
- DECODE (1):
  - One cycle.
  - Opcode classified as R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI or AUIPC.
  - JALR requires funct3=000; any other opcode or funct3 is illegal → TRAP with cause 01.
  - Otherwise next state EXEC.
- EXEC (2): one cycle. LOAD/STORE → MEM; all others → WB.
- MEM (3):
  - dmem_req=1; dmem_we=1 for STORE.
  - A wait counter starts at 0 on entry.
  - On dmem_ready=1 → WB.
  - If the counter reaches MEM_TIMEOUT-1 without ready → TRAP with cause 10.
  - If ready and timeout occur in the same cycle, ready wins.
- WB (4), one cycle:
  - reg_we=1 for R, I-ALU, LOAD, JAL, JALR, LUI and AUIPC when rd≠0. It is never asserted for STORE or BRANCH.
  - pc_we=1 always.
  - pc_sel: BRANCH with branch_taken → 01; JAL → 01; JALR → 10; everything else → 00.
  - retire=1 and instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- TRAP (5):
  - All strobes are 0 and trap=1.
  - trap_cause holds until rst.
  - pc_we=0, so the PC freezes at the faulting instruction.
- States 6 and 7 are unreachable. If entered, go to TRAP with cause 01.
- Latency:
  - ALU/branch/jump instructions: 4 cycles with zero-wait fetch.
  - Loads/stores: 5 cycles plus data wait states.
  - Fetch wait states add 1:1.
- instr must stay stable from DECODE through WB. IR is written only in FETCH.

Decomposition:
- Shared package `rv_pkg` holds:
  - opcode constants (0010011, 0000011, 0100011, 0110011, 1100011, 1101111, 1100111, 0110111, 0010111);
  - state encodings;
  - pc_sel and trap_cause encodings.
- The same package is imported by the existing decoder.
- One natural sub-module, `opcode_classifier`: combinational, maps instr to a one-hot instruction class plus an illegal flag. Everything else stays in the FSM.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready tied 1 → states 0,1,2,4; ir_we in cycle 1; reg_we, pc_we and pc_sel=00 in cycle 4; retire pulse; instret=1.
- LW x3,0(x1) (0x0000A183), dmem_ready after 3 MEM cycles → dmem_req high 3 cycles with dmem_we=0, then WB with reg_we=1; total 7 cycles.
- SW x2,0(x1) (0x0020A023), dmem_ready never asserted with MEM_TIMEOUT=16 → dmem_we=1 for 16 cycles, then trap=1 and trap_cause=10; pc_we never asserted; retire=0.
- BEQ x1,x2,8 (0x00208463) with branch_taken=1, then again with branch_taken=0 → WB pc_sel=01 then 00; reg_we=0 both times; instret increments by 2.
- Instruction 0xFFFFFFFF → DECODE then TRAP with trap_cause=01; assert rst for 1 cycle → state=0, trap=0, instret=0, imem_req=1 the cycle after release.
- imem_ready held low 5 cycles during FETCH, with rst pulsed mid-MEM of a prior LW → no ir_we while waiting; reset returns to FETCH with no dmem_req the following cycle.
